// File: rtl/next_pc_fetch_if.sv
// ----------------------------------------------------------------------------
// next_pc_fetch_if
// Bundles the signals exchanged between the PC/fetch sequencer and the rest of
// the single-cycle RV32 core: datapath control (jump selects, operands, commit)
// and the instruction-memory request/ack handshake.
//
// Modports:
//   master : the fetch sequencer (drives imem_req/imem_addr and the instr/pc
//            status outputs; receives selects, operands, commit and imem ack).
//   slave  : the surrounding datapath and instruction memory.
//
// Signals:
//   pcasrc, pcbsrc : A-operand (1 = imm) / B-operand (1 = rs1) selects
//   imm, rs1       : immediate and rs1 value of the current instruction
//   commit, halt   : datapath finished the instruction / it is a halt
//   imem_req/addr  : fetch request and address
//   imem_ack/rdata : fetch data valid and fetched word
//   instr/valid/pc : latched instruction, its validity and its PC
//   misalign       : sticky trap, misaligned target
//   halted         : sticky, halt committed
// ----------------------------------------------------------------------------
interface next_pc_fetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            pcasrc;
    logic            pcbsrc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            commit;
    logic            halt;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic [XLEN-1:0] pc;
    logic            misalign;
    logic            halted;

    modport master (
        input  pcasrc, pcbsrc, imm, rs1, commit, halt, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc, misalign, halted
    );

    modport slave (
        output pcasrc, pcbsrc, imm, rs1, commit, halt, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc, misalign, halted
    );
endinterface

// File: rtl/next_pc_fetch.sv
// ----------------------------------------------------------------------------
// next_pc_fetch
// PC register, next-PC adder and instruction-fetch sequencer for the
// single-cycle RV32 core. NextPC = A + B with A = pcasrc ? imm : 4 and
// B = pcbsrc ? rs1 : pc; bit 0 is cleared for register-relative jumps.
// A target with bit 1 set traps; a committed halt stops the core. Both
// terminal states persist until reset.
//
// Parameters:
//   XLEN     : datapath/address width
//   RESET_PC : PC loaded by reset (bits [1:0] must be zero)
//
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : next_pc_fetch_if.master (selects, operands, commit, imem handshake,
//           instr/pc/status outputs)
//   o_stat_commits, o_stat_redirects : only with BRANCH_STATS_EN defined;
//           count accepted commits and accepted redirecting commits.
//
// Build option: define BRANCH_STATS_EN to add the commit/redirect counters.
// All outputs are registered or decoded from the state register.
// ----------------------------------------------------------------------------
module next_pc_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef BRANCH_STATS_EN
    output logic [31:0]        o_stat_commits,
    output logic [31:0]        o_stat_redirects,
`endif
    next_pc_fetch_if.master    bus
);

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StExec,
        StHalt,
        StTrap
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [31:0]     r_instr;
    logic [31:0]     w_instr_next;

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_target;
    logic            w_accept;

    // Target adder; wraps modulo 2^XLEN by construction.
    always_comb begin
        w_op_a   = bus.pcasrc ? bus.imm : XLEN'(32'd4);
        w_op_b   = bus.pcbsrc ? bus.rs1 : r_pc;
        w_target = w_op_a + w_op_b;
        if (bus.pcbsrc) begin
            w_target[0] = 1'b0;
        end
    end

    // Commits are only meaningful while an instruction is being executed.
    assign w_accept = (r_state == StExec) && bus.commit;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        unique case (r_state)
            StBoot: begin
                w_state_next = StFetch;
            end
            StFetch: begin
                if (bus.imem_ack) begin
                    w_instr_next = bus.imem_rdata;
                    w_state_next = StExec;
                end
            end
            StExec: begin
                if (bus.commit) begin
                    // halt wins over a misaligned target
                    if (bus.halt) begin
                        w_state_next = StHalt;
                    end else if (w_target[1]) begin
                        w_state_next = StTrap;
                    end else begin
                        w_pc_next    = w_target;
                        w_state_next = StFetch;
                    end
                end
            end
            StHalt, StTrap: begin
                w_state_next = r_state;
            end
            default: begin
                w_state_next = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StBoot;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
        end
    end

    assign bus.imem_req    = (r_state == StFetch);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == StExec);
    assign bus.pc          = r_pc;
    assign bus.misalign    = (r_state == StTrap);
    assign bus.halted      = (r_state == StHalt);

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_commits;
    logic [31:0] r_stat_redirects;
    logic        w_redirect;

    // A redirect is a non-sequential select that actually leads to a new fetch.
    assign w_redirect = w_accept && !bus.halt && !w_target[1] && (bus.pcbsrc || bus.pcasrc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_commits   <= '0;
            r_stat_redirects <= '0;
        end else begin
            if (w_accept) begin
                r_stat_commits <= r_stat_commits + 32'd1;
            end
            if (w_redirect) begin
                r_stat_redirects <= r_stat_redirects + 32'd1;
            end
        end
    end

    assign o_stat_commits   = r_stat_commits;
    assign o_stat_redirects = r_stat_redirects;
`endif

endmodule

// File: tb/tb_next_pc_fetch.sv
// ----------------------------------------------------------------------------
// tb_next_pc_fetch
// Randomized, self-checking bench for next_pc_fetch. The stimulus process plays
// instruction memory and datapath, predicts each outcome from the jump rules
// with plain arithmetic and pushes it to a scoreboard queue; a negedge monitor
// pops and compares whenever the DUT starts a fetch, presents an instruction,
// traps or halts.
// ----------------------------------------------------------------------------
module tb_next_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam int KFetch = 0;
    localparam int KTrap  = 1;
    localparam int KHalt  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_redirects;
`endif

    next_pc_fetch_if #(.XLEN(32)) bus ();

    next_pc_fetch #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
`ifdef BRANCH_STATS_EN
        .o_stat_commits   (stat_commits),
        .o_stat_redirects (stat_redirects),
`endif
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q[$];
    logic [31:0] m_pc;
    int          m_commits;
    int          m_redirects;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    logic        prev_req, prev_valid, prev_mis, prev_halt;
    logic [31:0] cur_addr;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
            prev_mis   = 1'b0;
            prev_halt  = 1'b0;
        end else begin
            if (bus.imem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_fetch: got addr %h, required no request",
                             bus.imem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_kind", e.kind, KFetch);
                    check("fetch_addr", bus.imem_addr, e.addr);
                    cur_addr = e.addr;
                end
            end
            if (bus.instr_valid && !prev_valid) begin
                check("instr_word", bus.instr, memf(cur_addr));
                check("instr_pc", bus.pc, cur_addr);
            end
            if ((bus.misalign && !prev_mis) || (bus.halted && !prev_halt)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_stop: got misalign=%b halted=%b, required none",
                             bus.misalign, bus.halted);
                end else begin
                    e = exp_q.pop_front();
                    check("stop_kind", e.kind, bus.halted ? KHalt : KTrap);
                    check("stop_pc", bus.pc, e.addr);
                    check("stop_exclusive", bus.misalign & bus.halted, 1'b0);
                end
            end
            prev_req   = bus.imem_req;
            prev_valid = bus.instr_valid;
            prev_mis   = bus.misalign;
            prev_halt  = bus.halted;
        end
    end

    // ---------------- stimulus tasks ----------------
    // Asynchronous reset mid-cycle with a late ack floating across it.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_req", bus.imem_req, 1'b0);
        check("rst_valid", bus.instr_valid, 1'b0);
        check("rst_pc", bus.pc, RST_PC);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_misalign", bus.misalign, 1'b0);
        check("rst_halted", bus.halted, 1'b0);
`ifdef BRANCH_STATS_EN
        check("rst_stat_c", stat_commits, 32'h0);
        check("rst_stat_r", stat_redirects, 32'h0);
`endif
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom;
        tick();
        exp_q.delete();
        m_pc        = RST_PC;
        m_commits   = 0;
        m_redirects = 0;
        exp_q.push_back('{kind: KFetch, addr: RST_PC});
        #2 rst_n = 1'b1;
        #1;
        check("boot_req_low", bus.imem_req, 1'b0);
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        check("boot_one_cycle", bus.imem_req, 1'b1);
        check("late_ack_ignored", bus.instr_valid, 1'b0);
        check("late_ack_instr", bus.instr, 32'h0);
    endtask

    // Answer the pending fetch after dly cycles; optionally poke commit meanwhile.
    task automatic serve(input int dly, input bit poke);
        int          n;
        logic [31:0] a;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!bus.imem_req) begin
            check("req_timeout", bus.imem_req, 1'b1);
            return;
        end
        a = bus.imem_addr;
        for (int i = 0; i < dly; i++) begin
            if (poke) begin
                bus.commit = 1'b1;
                bus.pcasrc = 1'($urandom);
                bus.pcbsrc = 1'($urandom);
                bus.imm    = $urandom;
                bus.rs1    = $urandom;
            end
            tick();
            check("req_hold", bus.imem_req, 1'b1);
            check("addr_hold", bus.imem_addr, a);
            check("no_valid_in_fetch", bus.instr_valid, 1'b0);
        end
        bus.commit     = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memf(a);
        tick();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        check("valid_after_ack", bus.instr_valid, 1'b1);
    endtask

    task automatic do_commit(input bit b, input bit a, input logic [31:0] imm_v,
                             input logic [31:0] rs1_v, input bit h, input int pre);
        logic [31:0] nt;
        int          kind;
        for (int i = 0; i < pre; i++) begin
            tick();
            check("exec_hold", bus.instr_valid, 1'b1);
        end
        nt = (a ? imm_v : 32'd4) + (b ? rs1_v : m_pc);
        if (b) nt = nt & 32'hFFFF_FFFE;
        m_commits++;
        if (h) begin
            kind = KHalt;
            exp_q.push_back('{kind: KHalt, addr: m_pc});
        end else if (nt[1]) begin
            kind = KTrap;
            exp_q.push_back('{kind: KTrap, addr: m_pc});
        end else begin
            kind = KFetch;
            if (a || b) m_redirects++;
            m_pc = nt;
            exp_q.push_back('{kind: KFetch, addr: nt});
        end
        bus.pcbsrc = b;
        bus.pcasrc = a;
        bus.imm    = imm_v;
        bus.rs1    = rs1_v;
        bus.halt   = h;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        bus.halt   = 1'b0;
        check("commit_to_req", bus.imem_req, (kind == KFetch) ? 1'b1 : 1'b0);
        check("commit_valid_drop", bus.instr_valid, 1'b0);
    endtask

    task automatic check_stats();
`ifdef BRANCH_STATS_EN
        check("stat_commits", stat_commits, m_commits);
        check("stat_redirects", stat_redirects, m_redirects);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r_imm, r_rs1;
        int          sel;
        rst_n          = 1'b0;
        bus.pcasrc     = 1'b0;
        bus.pcbsrc     = 1'b0;
        bus.imm        = '0;
        bus.rs1        = '0;
        bus.commit     = 1'b0;
        bus.halt       = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        m_pc           = RST_PC;
        m_commits      = 0;
        m_redirects    = 0;
        tick();

        // Boot with immediate acks, then directed jumps.
        do_reset();
        serve(0, 1'b0);
        do_commit(1'b1, 1'b1, 32'h0, 32'h100, 1'b0, 0);
        serve(0, 1'b0);
        do_commit(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        serve(0, 1'b0);
        do_commit(1'b0, 1'b1, -32'sd4, 32'h0, 1'b0, 0);
        serve(0, 1'b0);
        do_commit(1'b0, 1'b1, -32'sd8, 32'h0, 1'b0, 0);
        serve(0, 1'b0);
        do_commit(1'b1, 1'b1, 32'h4, 32'h2001, 1'b0, 0);
        serve(5, 1'b1);
        do_commit(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFC, 1'b0, 0);
        serve(1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel   = int'($urandom_range(0, 3));
            r_imm = $urandom & 32'hFFFF_FFFC;
            r_rs1 = $urandom & 32'hFFFF_FFFD;
            do_commit(sel[1], sel[0], r_imm, r_rs1, 1'b0, int'($urandom_range(0, 2)));
            serve(int'($urandom_range(0, 3)), 1'($urandom));
        end
        check_stats();

        // Reset while a fetch is outstanding.
        do_commit(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        tick();
        tick();
        do_reset();
        serve(0, 1'b0);

        // Misaligned target traps and freezes.
        do_commit(1'b1, 1'b1, 32'h0, 32'h100, 1'b0, 0);
        serve(0, 1'b0);
        do_commit(1'b0, 1'b1, 32'h6, 32'h0, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            bus.commit   = 1'($urandom);
            bus.imem_ack = 1'($urandom);
            tick();
            check("trap_req", bus.imem_req, 1'b0);
            check("trap_pc", bus.pc, 32'h100);
            check("trap_flag", bus.misalign, 1'b1);
            check("trap_valid", bus.instr_valid, 1'b0);
        end
        bus.commit   = 1'b0;
        bus.imem_ack = 1'b0;

        // Stats and halt priority over misalign.
        do_reset();
        serve(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_commit(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
            serve(0, 1'b0);
        end
        do_commit(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 0);
        serve(0, 1'b0);
        do_commit(1'b1, 1'b0, 32'h0, 32'h200, 1'b0, 0);
        serve(0, 1'b0);
`ifdef BRANCH_STATS_EN
        check("stat_commits_5", stat_commits, 32'd5);
        check("stat_redirects_2", stat_redirects, 32'd2);
`endif
        do_commit(1'b0, 1'b1, 32'h2, 32'h0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_flag", bus.halted, 1'b1);
            check("halt_no_trap", bus.misalign, 1'b0);
            check("halt_req", bus.imem_req, 1'b0);
        end
        check_stats();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
